// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared types, flag indices and FP32 classification helper
//               for the divider issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    typedef enum logic [2:0] {
        ZERO,
        DENORM,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RES,
        RESP
    } issue_state_e;

    localparam int FLG_TO = 4;
    localparam int FLG_NV = 3;
    localparam int FLG_DZ = 2;
    localparam int FLG_OF = 1;
    localparam int FLG_UF = 0;

    localparam logic [31:0] CANON_NAN = 32'h7FC00000;

    function automatic fp_class_e fp_classify(input logic [31:0] x);
        fp_class_e cls;
        if (x[30:23] == 8'h00) begin
            cls = (x[22:0] == 23'd0) ? ZERO : DENORM;
        end else if (x[30:23] == 8'hFF) begin
            cls = (x[22:0] == 23'd0) ? INF : NAN;
        end else begin
            cls = NORMAL;
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fpu_cmd_fifo
// Description : In-order command FIFO; push is refused when full even if a
//               pop occurs in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == c_FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_div_issue.sv
`default_nettype none
// ============================================================================
// Module      : fpu_div_issue
// Description : Buffers tagged divide commands and issues them one at a time
//               to the FP32 divider, returning result, tag and IEEE flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_div_issue
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 512
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [31:0]            cmd_a,
    input  logic [31:0]            cmd_b,
    input  logic [TAG_W-1:0]       cmd_tag,
    output logic                   div_valid,
    output logic [31:0]            div_din1,
    output logic [31:0]            div_din2,
    input  logic [31:0]            div_result,
    input  logic                   div_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_result,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic [4:0]             rsp_flags,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int c_ENT_W = TAG_W + 64;
    localparam int c_TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

    issue_state_e         r_state;
    issue_state_e         w_state_next;
    logic [c_ENT_W-1:0]   w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_capture;
    logic                 w_timeout;
    logic [31:0]          r_op_a;
    logic [31:0]          r_op_b;
    logic [TAG_W-1:0]     r_op_tag;
    logic [c_TMR_W-1:0]   r_timer;
    logic [31:0]          r_rsp_result;
    logic [TAG_W-1:0]     r_rsp_tag;
    logic [4:0]           r_rsp_flags;
    logic [4:0]           w_flags;
    fp_class_e            w_cls_a;
    fp_class_e            w_cls_b;
    fp_class_e            w_cls_r;
    logic                 w_a_fin;
    logic                 w_b_fin;

    fpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (cmd_valid),
        .i_wdata ({cmd_tag, cmd_b, cmd_a}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign cmd_ready  = ~w_full;
    assign div_din1   = r_op_a;
    assign div_din2   = r_op_b;
    assign rsp_result = r_rsp_result;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_flags  = r_rsp_flags;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        div_valid    = 1'b0;
        rsp_valid    = 1'b0;
        busy         = (r_state != IDLE) || !w_empty;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                div_valid    = 1'b1;
                w_state_next = WAIT_RES;
            end
            WAIT_RES: begin
                // A completion in the expiry cycle still wins over the watchdog.
                if (div_ready) begin
                    w_capture    = 1'b1;
                    w_state_next = RESP;
                end else if (r_timer == c_TMR_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_cls_a = fp_classify(r_op_a);
    assign w_cls_b = fp_classify(r_op_b);
    assign w_cls_r = fp_classify(div_result);
    assign w_a_fin = (w_cls_a != INF) && (w_cls_a != NAN);
    assign w_b_fin = (w_cls_b != INF) && (w_cls_b != NAN);

    always_comb begin
        w_flags         = '0;
        w_flags[FLG_NV] = (w_cls_r == NAN) && (w_cls_a != NAN) && (w_cls_b != NAN);
        w_flags[FLG_DZ] = (w_cls_b == ZERO) && w_a_fin && (w_cls_a != ZERO);
        w_flags[FLG_OF] = (w_cls_r == INF) && w_a_fin && (w_cls_b != ZERO);
        w_flags[FLG_UF] = (div_result[30:23] == 8'h00) && w_a_fin &&
                          (w_cls_a != ZERO) && w_b_fin;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_tag     <= '0;
            r_timer      <= '0;
            r_rsp_result <= '0;
            r_rsp_tag    <= '0;
            r_rsp_flags  <= '0;
        end else begin
            if (w_pop) begin
                r_op_a   <= w_head[31:0];
                r_op_b   <= w_head[63:32];
                r_op_tag <= w_head[64 +: TAG_W];
            end
            if (r_state == ISSUE) begin
                r_timer <= '0;
            end else if (r_state == WAIT_RES) begin
                r_timer <= r_timer + c_TMR_W'(1);
            end
            if (w_capture) begin
                r_rsp_result <= div_result;
                r_rsp_tag    <= r_op_tag;
                r_rsp_flags  <= w_flags;
            end else if (w_timeout) begin
                r_rsp_result <= CANON_NAN;
                r_rsp_tag    <= r_op_tag;
                r_rsp_flags  <= 5'(1) << FLG_TO;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_div_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_div_issue
// Description : Self-checking bench for fpu_div_issue with a divider stub and
//               a queue-based reference model of the response stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_div_issue;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 512;
    localparam logic [111:0] RST_VEC = {1'b1, 111'd0};

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] res;
        logic [4:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [3:0]  cmd_tag = '0;
    logic        div_valid;
    logic [31:0] div_din1;
    logic [31:0] div_din2;
    logic [31:0] div_result = '0;
    logic        div_ready = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic [4:0]  rsp_flags;
    logic        busy;
    logic [2:0]  fifo_count;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   next_res_idx = 0;
    bit   prod_done = 1'b1;

    // divider stub state
    logic [31:0] res_mem [0:255];
    logic [31:0] stub_res = '0;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    int          issue_cnt = 0;
    int          stub_cnt = 0;
    bit          stub_on = 1'b1;
    int          stub_lat_max = 1;
    int          pulse_req = 0;
    int          pulse_done = 0;

    fpu_div_issue #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_tag    (cmd_tag),
        .div_valid  (div_valid),
        .div_din1   (div_din1),
        .div_din2   (div_din2),
        .div_result (div_result),
        .div_ready  (div_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .rsp_flags  (rsp_flags),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Divider stub: answers each issue after a random latency with the result
    // the test queued for that issue; can also inject stray completion pulses.
    always @(negedge clk) begin
        div_ready = 1'b0;
        if (!reset) begin
            stub_cnt = 0;
        end else begin
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    div_ready  = 1'b1;
                    div_result = stub_res;
                end
            end
            if (pulse_req != pulse_done) begin
                pulse_done++;
                div_ready  = 1'b1;
                div_result = $urandom;
            end
            if (div_valid) begin
                last_a   = div_din1;
                last_b   = div_din2;
                stub_res = res_mem[issue_cnt % 256];
                issue_cnt++;
                if (stub_on) stub_cnt = $urandom_range(1, stub_lat_max);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout elapsed=%0t limit=2000000", $time);
        $fatal(1);
    end

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction
    function automatic bit is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 0);
    endfunction
    function automatic bit is_zero(input logic [31:0] x);
        return x[30:0] == 0;
    endfunction

    function automatic logic [4:0] ref_flags(input logic [31:0] a, b, r);
        bit a_fin = !is_nan(a) && !is_inf(a);
        bit b_fin = !is_nan(b) && !is_inf(b);
        bit nv = is_nan(r) && !is_nan(a) && !is_nan(b);
        bit dz = is_zero(b) && a_fin && !is_zero(a);
        bit of = is_inf(r) && a_fin && !is_zero(b);
        bit uf = (r[30:23] == 0) && a_fin && !is_zero(a) && b_fin;
        return {1'b0, nv, dz, of, uf};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0:       return {s, 31'd0};
            1:       return {s, 8'hFF, 23'd0};
            2:       return {s, 8'hFF, 1'b1, 22'($urandom)};
            3:       return {s, 8'd0, 23'($urandom_range(1, 8388607))};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    function automatic logic [111:0] outs_vec();
        return {cmd_ready, div_valid, div_din1, div_din2, rsp_valid, rsp_result,
                rsp_tag, rsp_flags, busy, fifo_count};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] a, b, input logic [3:0] tag,
                            input logic [31:0] res, exp_res, input logic [4:0] exp_flags);
        int n = 0;
        res_mem[next_res_idx % 256] = res;
        next_res_idx++;
        cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        while (!cmd_ready && n < 3000) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL cmd_accept tag=%0d waited=%0d limit=3000", tag, n);
        end else begin
            tick();
            exp_q.push_back('{tag: tag, res: exp_res, flags: exp_flags});
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget, input bit rnd);
        int   n = 0;
        bit   hold = 1'b0;
        exp_t held_v = '0;
        exp_t e;
        while ((exp_q.size() > 0 || !prod_done) && n < budget) begin
            rsp_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (hold) begin
                checks++;
                if (!rsp_valid || {rsp_tag, rsp_result, rsp_flags} !== held_v) begin
                    failures++;
                    $display("FAIL rsp_hold got v=%b %h required v=1 %h", rsp_valid,
                             {rsp_tag, rsp_result, rsp_flags}, held_v);
                end
            end
            hold = 1'b0;
            if (rsp_valid) begin
                if (rsp_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL rsp_unexpected got tag=%0d required none", rsp_tag);
                    end else begin
                        e = exp_q.pop_front();
                        if ({rsp_tag, rsp_result, rsp_flags} !== e) begin
                            failures++;
                            $display("FAIL rsp_data got tag=%0d res=%h flg=%b required tag=%0d res=%h flg=%b",
                                     rsp_tag, rsp_result, rsp_flags, e.tag, e.res, e.flags);
                        end
                    end
                end else begin
                    hold   = 1'b1;
                    held_v = {rsp_tag, rsp_result, rsp_flags};
                end
            end
            tick();
            n++;
        end
        rsp_ready = 1'b0;
        if (exp_q.size() > 0 || !prod_done) begin
            checks++; failures++;
            $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if (outs_vec() !== RST_VEC) begin
            failures++;
            $display("FAIL reset_values got %h required %h", outs_vec(), RST_VEC);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_div_basic();
        int ic0 = issue_cnt;
        stub_lat_max = 3;
        send_cmd(32'h40C00000, 32'h40000000, 4'd3, 32'h40400000, 32'h40400000, 5'b00000);
        checks++;
        if (div_valid !== 1'b0) begin failures++; $display("FAIL lat_push got %b required 0", div_valid); end
        tick();
        checks++;
        if (div_valid !== 1'b1) begin failures++; $display("FAIL lat_issue got %b required 1", div_valid); end
        tick();
        checks++;
        if (div_valid !== 1'b0) begin failures++; $display("FAIL lat_after got %b required 0", div_valid); end
        drain(100, 1'b0);
        checks++;
        if (issue_cnt - ic0 != 1) begin
            failures++; $display("FAIL issue_pulses got %0d required 1", issue_cnt - ic0);
        end
        checks++;
        if ({last_a, last_b} !== {32'h40C00000, 32'h40000000}) begin
            failures++; $display("FAIL div_operands got %h %h required 40c00000 40000000", last_a, last_b);
        end
    endtask

    task automatic test_special();
        send_cmd(32'h3F800000, 32'h00000000, 4'd1, 32'h7F800000, 32'h7F800000, 5'b00100);
        drain(100, 1'b0);
        send_cmd(32'h00000000, 32'h00000000, 4'd2, 32'hFFC00000, 32'hFFC00000, 5'b01000);
        drain(100, 1'b0);
        send_cmd(32'h7F000000, 32'h3E800000, 4'd4, 32'h7F800000, 32'h7F800000, 5'b00010);
        drain(100, 1'b0);
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b0;
        stub_lat_max = 2;
        for (int i = 0; i < 5; i++) begin
            res_mem[next_res_idx % 256] = 32'h3F800000 + i;
            next_res_idx++;
            cmd_a = 32'h40000000 + i; cmd_b = 32'h3F800000; cmd_tag = 4'(i); cmd_valid = 1'b1;
            checks++;
            if (cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_accept i=%0d got %b required 1", i, cmd_ready); end
            tick();
            exp_q.push_back('{tag: 4'(i), res: 32'h3F800000 + i, flags: 5'b00000});
        end
        res_mem[next_res_idx % 256] = 32'h3F800005;
        next_res_idx++;
        cmd_a = 32'h40000005; cmd_tag = 4'd5;
        repeat (2) tick();
        checks++;
        if ({cmd_ready, fifo_count} !== {1'b0, 3'd4}) begin
            failures++; $display("FAIL bp_full got rdy=%b cnt=%0d required rdy=0 cnt=4", cmd_ready, fifo_count);
        end
        fork
            drain(3000, 1'b0);
            begin
                int n = 0;
                while (!cmd_ready && n < 3000) begin tick(); n++; end
                if (cmd_ready) begin
                    tick();
                    exp_q.push_back('{tag: 4'd5, res: 32'h3F800005, flags: 5'b00000});
                end else begin
                    checks++; failures++;
                    $display("FAIL bp_sixth waited=%0d limit=3000", n);
                end
                cmd_valid = 1'b0;
            end
        join
        repeat (3) tick();
        checks++;
        if ({busy, fifo_count} !== 4'b0) begin
            failures++; $display("FAIL bp_idle got busy=%b cnt=%0d required 0 0", busy, fifo_count);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int cyc = 0;
        stub_on = 1'b0;
        rsp_ready = 1'b0;
        send_cmd(32'h3F800000, 32'h40000000, 4'd7, 32'h0, 32'h7FC00000, 5'b10000);
        while (!div_valid && n < 10) begin tick(); n++; end
        while (!rsp_valid && cyc < TIMEOUT + 50) begin tick(); cyc++; end
        checks++;
        if (cyc != TIMEOUT + 1) begin
            failures++; $display("FAIL timeout_latency got %0d required %0d", cyc, TIMEOUT + 1);
        end
        pulse_req++;
        repeat (2) tick();
        checks++;
        if ({rsp_valid, rsp_tag, rsp_result, rsp_flags} !== {1'b1, 4'd7, 32'h7FC00000, 5'b10000}) begin
            failures++; $display("FAIL late_pulse_resp got v=%b %h %h %b required v=1 7 7fc00000 10000",
                                 rsp_valid, rsp_tag, rsp_result, rsp_flags);
        end
        drain(20, 1'b0);
        pulse_req++;
        repeat (3) tick();
        checks++;
        if ({rsp_valid, busy, fifo_count} !== 5'b0) begin
            failures++; $display("FAIL late_pulse_idle got v=%b busy=%b cnt=%0d required 0 0 0",
                                 rsp_valid, busy, fifo_count);
        end
        stub_on = 1'b1;
    endtask

    task automatic test_reset_midop();
        int  ic1;
        bit  seen = 1'b0;
        stub_on = 1'b0;
        rsp_ready = 1'b0;
        send_cmd(32'h40000000, 32'h3F800000, 4'd8, 32'h0, 32'h0, 5'b0);
        send_cmd(32'h40400000, 32'h3F800000, 4'd9, 32'h0, 32'h0, 5'b0);
        send_cmd(32'h40800000, 32'h3F800000, 4'd10, 32'h0, 32'h0, 5'b0);
        repeat (3) tick();
        checks++;
        if ({busy, fifo_count} !== {1'b1, 3'd2}) begin
            failures++; $display("FAIL midop_setup got busy=%b cnt=%0d required 1 2", busy, fifo_count);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (outs_vec() !== RST_VEC) begin
            failures++; $display("FAIL midop_reset got %h required %h", outs_vec(), RST_VEC);
        end
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        stub_on = 1'b1;
        rsp_ready = 1'b1;
        ic1 = issue_cnt;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid || div_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen || issue_cnt != ic1) begin
            failures++; $display("FAIL midop_flushed got activity=%b issues=%0d required 0 0", seen, issue_cnt - ic1);
        end
        rsp_ready = 1'b0;
        next_res_idx = issue_cnt;
    endtask

    task automatic test_random();
        prod_done = 1'b0;
        stub_lat_max = 6;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [31:0] a = rand_fp();
                    logic [31:0] b = rand_fp();
                    logic [31:0] r = rand_fp();
                    repeat ($urandom_range(0, 2)) tick();
                    send_cmd(a, b, 4'(i), r, r, ref_flags(a, b, r));
                end
                prod_done = 1'b1;
            end
            drain(6000, 1'b1);
        join
    endtask

    initial begin
        for (int i = 0; i < 256; i++) res_mem[i] = '0;
        test_reset();
        test_div_basic();
        test_special();
        test_back_to_back();
        test_timeout();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
